spi_rx_fifo: RTL and testbench
==============================

// Module: spi_rx_fifo
//
// PURPOSE
// Receive-side word buffer directly downstream of spi_interface. Captures each
// completed MOSI word (mosi_buffer / mosi_buffer_valid) exactly once into a
// DEPTH-entry FIFO in the sys_clk domain. Presents the words to the consumer
// over a first-word-fall-through valid/ready port, with occupancy and sticky
// overflow status.
//
// PARAMETERS
// WIDTH  32  word width; must match spi_interface WIDTH
// DEPTH  8   FIFO entries; power of two, >= 2
//
// PORTS
// sys_clk            in   1                  system clock, all logic on posedge
// sys_reset_n        in   1                  async active-low reset
// mosi_buffer        in   WIDTH              received word from spi_interface
// mosi_buffer_valid  in   1                  word valid (level; may stay high many cycles)
// rd_data            out  WIDTH              head-of-FIFO word
// rd_valid           out  1                  rd_data holds a valid word (= ~empty)
// rd_ready           in   1                  consumer accepts rd_data this cycle
// count              out  $clog2(DEPTH+1)    entries currently stored, 0..DEPTH
// full               out  1                  count == DEPTH
// empty              out  1                  count == 0
// overflow           out  1                  sticky: a word was dropped while full
// overflow_clr       in   1                  1-cycle pulse clears overflow
//
// BEHAVIOUR
// - Reset (async assert, sync release by design): wr_ptr, rd_ptr, count = 0;
//   valid_q = 0; overflow = 0. Outputs: rd_valid = 0, empty = 1, full = 0,
//   rd_data = 0. Memory contents are not reset.
// - Capture: valid_q <= mosi_buffer_valid every cycle.
//   push_req = mosi_buffer_valid & ~valid_q (rising edge). One push per word,
//   however long valid stays high. Valid already high when reset releases
//   counts as a rising edge on the first cycle.
// - Pop: pop = rd_valid & rd_ready. rd_ready while empty is ignored.
// - Push accepted when push_req & (~full | pop). An accepted push writes
//   mem[wr_ptr] <= mosi_buffer on the same edge.
// - Pointer arithmetic:
//   - wr_ptr / rd_ptr are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
//   - count += push_acc - pop, never outside 0..DEPTH.
// - Full with push_req and pop in the same cycle: the pop frees the slot and
//   the push is accepted. count stays DEPTH; no overflow.
// - Full with push_req and no pop: word dropped, FIFO unchanged,
//   overflow <= 1 on that edge.
// - overflow_clr clears overflow. If overflow_clr coincides with a drop,
//   set wins (overflow stays 1).
// - Empty with push_req and rd_ready in the same cycle: no pop, since
//   rd_valid = 0. The word is stored; rd_valid rises the next cycle.
// - Latency: a word written on edge N is visible on rd_data with rd_valid = 1
//   after edge N (FWFT, combinational read of mem[rd_ptr]).
//   - empty: rd_data = 0;
//   - otherwise: rd_data = mem[rd_ptr].
// - full, empty and rd_valid are decoded from the registered count. No
//   combinational path exists from rd_ready to full / count.
// - Reset mid-operation discards all stored words and the overflow flag.
//
// TESTING
// 1 Reset: hold sys_reset_n=0 -> rd_valid=0, empty=1, full=0, count=0,
//   overflow=0, rd_data=0.
// 2 Single word: 32'hdeadbeef with valid high 40 cycles -> exactly one entry
//   (count=1), rd_data=32'hdeadbeef; rd_ready 1 cycle -> count=0, empty=1.
// 3 Fill and order: push 32'h00000001..32'h00000008 (DEPTH=8), rd_ready=0
//   -> full=1, count=8; drain -> words read in order 1..8, then empty=1.
// 4 Overflow: full, push 32'hcafef00d with no pop -> count stays 8,
//   overflow=1, contents 1..8 intact; overflow_clr pulse -> overflow=0.
// 5 Full push+pop same cycle: full, push 32'h12345678 while rd_ready=1 ->
//   count stays 8, overflow=0, 32'h12345678 read last after the 7 remaining.
// 6 Wrap + reset: 20 push/pop pairs across pointer wrap -> data matches a
//   model; assert reset with count=5 -> count=0, empty=1 at once.

Source files
------------

// File: rtl/spi_rx_fifo.sv
// ---------------------------------------------------------------------------
// spi_rx_fifo
//
// Purpose:
//   Receive-side word buffer that sits directly after spi_interface. Each
//   completed MOSI word is captured once, on the rising edge of
//   mosi_buffer_valid, into a DEPTH-entry FIFO clocked by sys_clk. Words are
//   handed to the consumer over a first-word-fall-through valid/ready port.
//   The block also reports occupancy and a sticky overflow flag.
//
// Ports:
//   sys_clk            system clock; all logic runs on its rising edge
//   sys_reset_n        asynchronous active-low reset
//   mosi_buffer        received word from spi_interface
//   mosi_buffer_valid  word-valid level; it may stay high for many cycles
//   rd_data            head-of-FIFO word; reads 0 while empty
//   rd_valid           rd_data holds a valid word (same as ~empty)
//   rd_ready           consumer accepts rd_data this cycle
//   count              number of stored entries, 0..DEPTH
//   full               count == DEPTH
//   empty              count == 0
//   overflow           sticky; set when a word is dropped because the FIFO is full
//   overflow_clr       one-cycle pulse that clears overflow
// ---------------------------------------------------------------------------
module spi_rx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       sys_clk,
  input  logic                       sys_reset_n,
  input  logic [WIDTH-1:0]           mosi_buffer,
  input  logic                       mosi_buffer_valid,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  input  logic                       overflow_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic             valid_q, valid_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic push_req;
  logic pop;
  logic push_acc;
  logic drop;

  // Status comes only from the registered count, so rd_ready has no
  // combinational path to full or count.
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign rd_valid = ~empty;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];

  // valid_q is cleared by reset, so a valid that is already high when reset
  // releases is seen as a rising edge on the first cycle.
  assign push_req = mosi_buffer_valid & ~valid_q;
  assign pop      = rd_valid & rd_ready;
  // A same-cycle pop frees the slot, so a push into a full FIFO is still
  // accepted in that case.
  assign push_acc = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    valid_d    = mosi_buffer_valid;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push_acc) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)      rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push_acc, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // If a drop and a clear arrive together, the set takes priority.
    if (drop)              overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      valid_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; empty gates rd_data, so stale contents never
  // reach the output.
  always_ff @(posedge sys_clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= mosi_buffer;
  end

endmodule

// File: tb/tb_spi_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_spi_rx_fifo
//
// Purpose:
//   Self-checking bench for spi_rx_fifo with WIDTH=32 and DEPTH=8.
//
// Operation:
//   A short table of per-step input records drives the single-word and
//   empty-boundary cases. Each record also carries the occupancy and overflow
//   expected after that step. Hand-written sequences cover fill and drain,
//   overflow, push and pop together while full, pointer wrap, and resets.
//   A queue scoreboard receives each word the FIFO should accept when that
//   word is driven. The word is popped and compared when the DUT hands it out.
// ---------------------------------------------------------------------------
module tb_spi_rx_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic             sys_clk;
  logic             sys_reset_n;
  logic [WIDTH-1:0] mosi_buffer;
  logic             mosi_buffer_valid;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [3:0]       count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             overflow_clr;

  int checks;
  int failures;

  logic [WIDTH-1:0] sb_q [$];
  logic             model_ovf;
  logic             prev_valid;

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        ready;
    logic        clr;
    int          hold;
    int          exp_count;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [6];

  spi_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .sys_clk           (sys_clk),
    .sys_reset_n       (sys_reset_n),
    .mosi_buffer       (mosi_buffer),
    .mosi_buffer_valid (mosi_buffer_valid),
    .rd_data           (rd_data),
    .rd_valid          (rd_valid),
    .rd_ready          (rd_ready),
    .count             (count),
    .full              (full),
    .empty             (empty),
    .overflow          (overflow),
    .overflow_clr      (overflow_clr)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Compares every status output with the scoreboard's view of the FIFO.
  task automatic checkStatus(input string tag);
    checkOutput({tag, ".count"},    32'(count),    32'(sb_q.size()));
    checkOutput({tag, ".full"},     32'(full),     32'(sb_q.size() == DEPTH));
    checkOutput({tag, ".empty"},    32'(empty),    32'(sb_q.size() == 0));
    checkOutput({tag, ".rd_valid"}, 32'(rd_valid), 32'(sb_q.size() != 0));
    checkOutput({tag, ".overflow"}, 32'(overflow), 32'(model_ovf));
    if (sb_q.size() != 0) checkOutput({tag, ".rd_head"}, rd_data, sb_q[0]);
    else                  checkOutput({tag, ".rd_zero"}, rd_data, 32'h0);
  endtask

  // Drives one clock cycle. The bench calls it about 1 ns after a rising
  // edge. Pops are scored before the edge. Status is checked 1 ns after it.
  task automatic applyStimulus(input logic valid, input logic [31:0] data,
                               input logic ready, input logic clr, input string tag);
    logic do_pop;
    logic push_req;
    mosi_buffer_valid = valid;
    mosi_buffer       = data;
    rd_ready          = ready;
    overflow_clr      = clr;
    @(negedge sys_clk);
    do_pop   = (sb_q.size() != 0) && ready;
    push_req = valid && !prev_valid;
    if (do_pop) begin
      checkOutput({tag, ".pop_data"}, rd_data, sb_q[0]);
      void'(sb_q.pop_front());
    end
    if (push_req && sb_q.size() < DEPTH) sb_q.push_back(data);
    else if (push_req)                   model_ovf = 1'b1;
    else if (clr)                        model_ovf = 1'b0;
    if (push_req && sb_q.size() == DEPTH && !do_pop && clr) model_ovf = model_ovf;
    prev_valid = valid;
    @(posedge sys_clk);
    #1;
    checkStatus(tag);
  endtask

  task automatic sendWord(input logic [31:0] data, input logic ready, input logic clr, input string tag);
    applyStimulus(1'b1, data, ready, clr, tag);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, tag);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2*DEPTH && sb_q.size() != 0; i++)
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, tag);
    checkOutput({tag, ".drained_empty"}, 32'(empty), 32'h1);
  endtask

  // Asserts reset and checks the outputs before any clock edge, because the
  // reset is asynchronous. It then releases reset away from the clock edge.
  task automatic doReset(input logic valid_during, input string tag);
    mosi_buffer_valid = valid_during;
    rd_ready          = 1'b0;
    overflow_clr      = 1'b0;
    sys_reset_n       = 1'b0;
    #1;
    sb_q.delete();
    model_ovf  = 1'b0;
    prev_valid = 1'b0;
    checkStatus(tag);
    repeat (2) @(posedge sys_clk);
    #1;
    sys_reset_n = 1'b1;
  endtask

  initial begin
    checks            = 0;
    failures          = 0;
    model_ovf         = 1'b0;
    prev_valid        = 1'b0;
    sys_reset_n       = 1'b1;
    mosi_buffer       = '0;
    mosi_buffer_valid = 1'b0;
    rd_ready          = 1'b0;
    overflow_clr      = 1'b0;

    vecs[0] = '{valid:1'b1, data:32'hdeadbeef, ready:1'b0, clr:1'b0, hold:40, exp_count:1, exp_ovf:1'b0};
    vecs[1] = '{valid:1'b0, data:32'h0,        ready:1'b0, clr:1'b0, hold:2,  exp_count:1, exp_ovf:1'b0};
    vecs[2] = '{valid:1'b0, data:32'h0,        ready:1'b1, clr:1'b0, hold:1,  exp_count:0, exp_ovf:1'b0};
    vecs[3] = '{valid:1'b0, data:32'h0,        ready:1'b1, clr:1'b0, hold:2,  exp_count:0, exp_ovf:1'b0};
    vecs[4] = '{valid:1'b1, data:32'ha5a5a5a5, ready:1'b1, clr:1'b0, hold:1,  exp_count:1, exp_ovf:1'b0};
    vecs[5] = '{valid:1'b0, data:32'h0,        ready:1'b1, clr:1'b0, hold:1,  exp_count:0, exp_ovf:1'b0};

    @(posedge sys_clk);
    #1;
    doReset(1'b0, "reset");

    // Single word with a long valid, then the empty-boundary cases.
    for (int v = 0; v < 6; v++) begin
      for (int h = 0; h < vecs[v].hold; h++)
        applyStimulus(vecs[v].valid, vecs[v].data, vecs[v].ready, vecs[v].clr, $sformatf("vec%0d", v));
      checkOutput($sformatf("vec%0d.tbl_count", v), 32'(count), 32'(vecs[v].exp_count));
      checkOutput($sformatf("vec%0d.tbl_ovf", v), 32'(overflow), 32'(vecs[v].exp_ovf));
    end

    // Fill to full, then drain in order.
    for (int i = 1; i <= DEPTH; i++) sendWord(32'(i), 1'b0, 1'b0, "fill");
    checkOutput("fill.full", 32'(full), 32'h1);
    checkOutput("fill.count", 32'(count), 32'd8);
    drain("drain1");

    // Overflow: the dropped word leaves the contents intact. A clear that
    // arrives together with a drop loses to the set.
    for (int i = 1; i <= DEPTH; i++) sendWord(32'(i), 1'b0, 1'b0, "refill");
    sendWord(32'hcafef00d, 1'b0, 1'b0, "ovf_drop");
    checkOutput("ovf.count", 32'(count), 32'd8);
    checkOutput("ovf.flag", 32'(overflow), 32'h1);
    sendWord(32'hbadc0de0, 1'b0, 1'b1, "ovf_clr_vs_drop");
    checkOutput("ovf.set_wins", 32'(overflow), 32'h1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, "ovf_clr");
    checkOutput("ovf.cleared", 32'(overflow), 32'h0);

    // Push and pop in the same cycle while full.
    sendWord(32'h12345678, 1'b1, 1'b0, "full_pushpop");
    checkOutput("fpp.count", 32'(count), 32'd8);
    checkOutput("fpp.ovf", 32'(overflow), 32'h0);
    drain("drain2");

    // Push/pop pairs that carry both pointers across the wrap point.
    for (int i = 0; i < 20; i++) begin
      sendWord($urandom, 1'b0, 1'b0, "wrap_push");
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, "wrap_pop");
    end

    // Reset in the middle of operation with five words stored.
    for (int i = 0; i < 5; i++) sendWord($urandom, 1'b0, 1'b0, "pre_reset");
    checkOutput("pre_reset.count", 32'(count), 32'd5);
    doReset(1'b0, "mid_reset");
    checkOutput("mid_reset.count", 32'(count), 32'd0);

    // A valid that is already high when reset releases counts as a new word.
    doReset(1'b1, "reset_valid_high");
    applyStimulus(1'b1, 32'h0badf00d, 1'b0, 1'b0, "valid_at_release");
    applyStimulus(1'b1, 32'h0badf00d, 1'b0, 1'b0, "valid_held");
    checkOutput("release.count", 32'(count), 32'd1);
    drain("drain3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
